// File: rtl/sc_lane_pkg.sv
// sc_lane_pkg: shared state encoding, level count and per-lane car patterns for sc_lane_ctrl
//   state_t  FSM state encoding (IDLE, LOAD, RUN, HOLD)
//   LEVELS   number of speed levels
//   LANES    number of lanes with a pattern row
//   PATTERN  [lane][level] parallel-load pattern for SC_REGDI
package sc_lane_pkg;
    localparam int LEVELS = 4;
    localparam int LANES  = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;
    localparam logic [7:0] PATTERN [LANES][LEVELS] = '{
        '{8'hC6, 8'hCC, 8'hDA, 8'hEE},
        '{8'h63, 8'h33, 8'h5B, 8'h77},
        '{8'h8C, 8'h99, 8'hB5, 8'hDD},
        '{8'h31, 8'h66, 8'h6D, 8'hBB}
    };
endpackage

// File: rtl/sc_lane_ctrl_if.sv
// sc_lane_ctrl_if: control/status bundle between the game FSM and one lane sequencer
//   start, levelup, pause            commands into the lane
//   load_shift, vel, bus_out         SC_REGDI drive (load strobe, shift tick, pattern)
//   level, running                   status back to the game FSM
interface sc_lane_ctrl_if #(
    parameter int DW = 8
);
    logic          start;
    logic          levelup;
    logic          pause;
    logic          load_shift;
    logic          vel;
    logic [DW-1:0] bus_out;
    logic [1:0]    level;
    logic          running;
    modport master (
        output start, levelup, pause,
        input  load_shift, vel, bus_out, level, running
    );
    modport slave (
        input  start, levelup, pause,
        output load_shift, vel, bus_out, level, running
    );
endinterface

// File: rtl/sc_tick_div.sv
// sc_tick_div: loadable, freezable down-counter producing a registered terminal-count pulse
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load period-1 into the counter
//   en          count down; wraps to period-1 after reaching 0
//   arm         allows tc in the next cycle (caller passes "will be running")
//   period      tick period in clocks (>= 2)
//   tc          one-cycle pulse during the cycle the counter sits at 0
module sc_tick_div #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic         arm,
    input  logic [W-1:0] period,
    output logic         tc
);
    logic [W-1:0] cnt, cnt_d;
    always_comb cnt_d = load ? period - W'(1) : !en ? cnt : cnt == '0 ? period - W'(1) : cnt - W'(1);
    // tc is registered from the next count so it lines up with the cycle the counter is 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else begin
            cnt <= cnt_d;
            tc  <= arm && cnt_d == '0;
        end
    end
endmodule

// File: rtl/sc_lane_ctrl.sv
// sc_lane_ctrl: lane sequencer that loads SC_REGDI with the level pattern and issues velocity ticks
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side: start/levelup/pause in; load_shift/vel/bus_out/level/running out
module sc_lane_ctrl
    import sc_lane_pkg::*;
#(
    parameter int          DATAWIDTH_BUS = 8,
    parameter int          DIVWIDTH      = 24,
    parameter int unsigned DIV_BASE      = 12_500_000,
    parameter int          LANE_ID       = 0
) (
    input logic           clk,
    input logic           rst_n,
    sc_lane_ctrl_if.slave bus
);
    state_t              state, state_d;
    logic [1:0]          level, level_d, level_up;
    logic                pend, pend_d;
    logic                vel;
    logic [DIVWIDTH-1:0] base, shifted, period;
    assign level_up = level == 2'd3 ? 2'd3 : level + 2'd1;
    assign base     = DIVWIDTH'(DIV_BASE);
    assign shifted  = base >> level;
    assign period   = shifted < DIVWIDTH'(2) ? DIVWIDTH'(2) : shifted;
    // pend remembers a level-up taken while paused so the lane reloads on resume
    always_comb begin
        state_d = state;
        level_d = level;
        pend_d  = pend;
        if (bus.start) begin
            state_d = LOAD;
            level_d = 2'd0;
            pend_d  = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    if (bus.levelup) level_d = level_up;
                    else state_d = RUN;
                end
                RUN: begin
                    if (bus.levelup) begin
                        state_d = LOAD;
                        level_d = level_up;
                    end else if (bus.pause) state_d = HOLD;
                end
                HOLD: begin
                    if (bus.levelup) begin
                        level_d = level_up;
                        pend_d  = 1'b1;
                    end
                    if (!bus.pause) begin
                        state_d = (bus.levelup || pend) ? LOAD : RUN;
                        pend_d  = 1'b0;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            level          <= 2'd0;
            pend           <= 1'b0;
            bus.load_shift <= 1'b0;
            bus.running    <= 1'b0;
            bus.bus_out    <= DATAWIDTH_BUS'(PATTERN[LANE_ID][0]);
        end else begin
            state          <= state_d;
            level          <= level_d;
            pend           <= pend_d;
            bus.load_shift <= state_d == LOAD;
            bus.running    <= state_d == RUN;
            bus.bus_out    <= DATAWIDTH_BUS'(PATTERN[LANE_ID][level_d]);
        end
    end
    assign bus.level = level;
    assign bus.vel   = vel;
    // the counter advances in every RUN cycle, including the one in which pause is sampled
    sc_tick_div #(.W(DIVWIDTH)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == LOAD),
        .en     (state == RUN),
        .arm    (state_d == RUN),
        .period (period),
        .tc     (vel)
    );
endmodule

// File: tb/tb_sc_lane_ctrl.sv
// tb_sc_lane_ctrl: randomized and directed self-checking bench for sc_lane_ctrl (DIV_BASE=16, lane 0)
module tb_sc_lane_ctrl;
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_HOLD} mode_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    mode_t      m = M_IDLE;
    int         lvl = 0;
    bit         pend = 0;
    int         e = 0;
    logic [7:0] regdi = 8'h00;
    logic [7:0] pat [4] = '{8'hC6, 8'hCC, 8'hDA, 8'hEE};

    sc_lane_ctrl_if #(.DW(8)) bus ();
    sc_lane_ctrl #(.DIV_BASE(16), .LANE_ID(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int per(input int l);
        int p;
        p = 16 >> l;
        return p < 2 ? 2 : p;
    endfunction

    function automatic int sat(input int l);
        return l >= 3 ? 3 : l + 1;
    endfunction

    // ticks fall on every RUN cycle whose count of earlier RUN cycles since the load is P-1 mod P
    task automatic check_outputs();
        int p;
        p = per(lvl);
        chk("load_shift", bus.load_shift, m == M_LOAD);
        chk("running", bus.running, m == M_RUN);
        chk("vel", bus.vel, m == M_RUN && (e % p) == p - 1);
        chk("level", bus.level, lvl);
        chk("bus_out", bus.bus_out, pat[lvl]);
    endtask

    task automatic model_reset();
        m = M_IDLE;
        lvl = 0;
        pend = 0;
        e = 0;
    endtask

    task automatic step(input bit s, input bit u, input bit p);
        mode_t nm;
        int    nl;
        bit    np;
        nm = m;
        nl = lvl;
        np = pend;
        bus.start = s;
        bus.levelup = u;
        bus.pause = p;
        if (bus.load_shift) regdi = bus.bus_out;
        else if (bus.vel) regdi = {regdi[6:0], regdi[7]};
        if (s) begin
            nm = M_LOAD;
            nl = 0;
            np = 0;
        end else if (m == M_LOAD) begin
            if (u) nl = sat(lvl);
            else nm = M_RUN;
        end else if (m == M_RUN) begin
            if (u) begin
                nm = M_LOAD;
                nl = sat(lvl);
            end else if (p) nm = M_HOLD;
        end else if (m == M_HOLD) begin
            if (u) begin
                nl = sat(lvl);
                np = 1;
            end
            if (!p) begin
                nm = np ? M_LOAD : M_RUN;
                np = 0;
            end
        end
        if (m == M_RUN) e++;
        if (nm == M_LOAD) e = 0;
        @(posedge clk);
        cyc++;
        m = nm;
        lvl = nl;
        pend = np;
        #1;
        check_outputs();
    endtask

    initial begin
        int  w;
        int  nv;
        bit  s;
        bit  u;
        bit  pz;
        bus.start = 0;
        bus.levelup = 0;
        bus.pause = 0;
        pz = 0;
        // 1: reset held, then idle without START
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load", bus.load_shift, 0);
        chk("rst_vel", bus.vel, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_bus", bus.bus_out, 8'hC6);
        rst_n = 1'b1;
        repeat (100) step(0, 0, 0);
        // 2: start, ticks every 16 cycles, attached register rotates C6 -> 8D
        step(1, 0, 0);
        chk("start_load", bus.load_shift, 1);
        chk("start_bus", bus.bus_out, 8'hC6);
        repeat (17) step(0, 0, 0);
        chk("regdi_first_tick", regdi, 8'h8D);
        repeat (40) step(0, 0, 0);
        // 3: four level-ups, saturating at 3
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 0);
            chk("lvlup_level", bus.level, k < 3 ? k + 1 : 3);
            chk("lvlup_load", bus.load_shift, 1);
            repeat (20) step(0, 0, 0);
        end
        // 4: pause 5 cycles, 3 cycles after a tick at level 0
        step(1, 0, 0);
        w = 0;
        while (!bus.vel && w < 40) begin
            step(0, 0, 0);
            w++;
        end
        chk("vel_seen", bus.vel, 1);
        repeat (3) step(0, 0, 0);
        repeat (5) step(0, 0, 1);
        w = 0;
        nv = 0;
        while (!bus.vel && w < 40) begin
            step(0, 0, 0);
            w++;
        end
        chk("pause_resume_gap", w, 13);
        // 5: START and LEVELUP together at level 2
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);
        chk("pre_level", bus.level, 2);
        step(1, 1, 0);
        chk("startlvl_level", bus.level, 0);
        chk("startlvl_load", bus.load_shift, 1);
        chk("startlvl_bus", bus.bus_out, 8'hC6);
        step(0, 0, 0);
        chk("startlvl_single_load", bus.load_shift, 0);
        // 6: async reset pulse mid-RUN
        repeat (7) step(0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_load", bus.load_shift, 0);
        chk("arst_vel", bus.vel, 0);
        chk("arst_running", bus.running, 0);
        chk("arst_level", bus.level, 0);
        chk("arst_bus", bus.bus_out, 8'hC6);
        model_reset();
        regdi = 8'h00;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0);
            if (bus.vel) nv++;
        end
        chk("no_vel_after_rst", nv, 0);
        // random mix of start, level-up and pause
        for (int i = 0; i < 3000; i++) begin
            s = $urandom_range(63) == 0;
            u = (m != M_LOAD) && ($urandom_range(23) == 0);
            if ($urandom_range(15) == 0) pz = !pz;
            step(s, u, pz);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
